// File: rtl/result_drain.sv
// Drains len consecutive entries from the SA, FC or pool-address result buffer
// onto a valid/ready stream, keeping at most two reads outstanding.
module result_drain #(
  parameter int DATA_WIDTH  = 8,
  parameter int PADDR_WIDTH = 10,
  parameter int LEN_WIDTH   = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [1:0]             sel_i,
  input  logic [LEN_WIDTH-1:0]   len_i,
  output logic                   sa_data_rden_o,
  output logic [13:0]            sa_data_rdptr_o,
  input  logic [DATA_WIDTH-1:0]  sa_data_rdata_i,
  output logic                   fc_data_rden_o,
  output logic [9:0]             fc_data_rdptr_o,
  input  logic [DATA_WIDTH-1:0]  fc_data_rdata_i,
  output logic                   pool_address_rden_o,
  output logic [13:0]            pool_address_rdptr_o,
  input  logic [PADDR_WIDTH-1:0] pool_address_rdata_i,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic [PADDR_WIDTH-1:0] m_data_o,
  output logic                   m_last_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t                 r_state;
  logic [1:0]             r_sel;
  logic [LEN_WIDTH-1:0]   r_len;
  logic [LEN_WIDTH-1:0]   r_issued;
  logic [LEN_WIDTH-1:0]   r_accepted;
  logic                   r_inflight;
  logic [PADDR_WIDTH-1:0] r_fifo [2];
  logic                   r_wr_ptr;
  logic                   r_rd_ptr;
  logic [1:0]             r_count;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_err;

  logic                   w_pop;
  logic [2:0]             w_occ;
  logic                   w_issue;
  logic                   w_last_issue;
  logic                   w_last_pop;
  logic [PADDR_WIDTH-1:0] w_ret_data;

  assign w_pop = (r_count != 2'd0) && m_ready_i;
  // Occupancy as it will be next cycle if nothing new is issued; a pop this
  // cycle frees a slot immediately so issuing never stalls with ready high.
  assign w_occ = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = (r_state == S_READ) && (r_issued < r_len) && (w_occ < 3'd2);
  assign w_last_issue = w_issue && (r_issued == r_len - LEN_WIDTH'(1));
  assign w_last_pop = w_pop && (r_accepted == r_len - LEN_WIDTH'(1));

  always_comb begin
    w_ret_data = '0;
    case (r_sel)
      2'd0:    w_ret_data = PADDR_WIDTH'(sa_data_rdata_i);
      2'd1:    w_ret_data = PADDR_WIDTH'(fc_data_rdata_i);
      default: w_ret_data = pool_address_rdata_i;
    endcase
  end

  assign sa_data_rden_o       = w_issue && (r_sel == 2'd0);
  assign fc_data_rden_o       = w_issue && (r_sel == 2'd1);
  assign pool_address_rden_o  = w_issue && (r_sel == 2'd2);
  assign sa_data_rdptr_o      = sa_data_rden_o ? r_issued[13:0] : 14'd0;
  assign fc_data_rdptr_o      = fc_data_rden_o ? r_issued[9:0] : 10'd0;
  assign pool_address_rdptr_o = pool_address_rden_o ? r_issued[13:0] : 14'd0;

  assign m_valid_o = (r_count != 2'd0);
  assign m_data_o  = r_fifo[r_rd_ptr];
  assign m_last_o  = m_valid_o && (r_accepted == r_len - LEN_WIDTH'(1));
  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign err_o     = r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_sel      <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_accepted <= '0;
      r_inflight <= 1'b0;
      r_fifo[0]  <= '0;
      r_fifo[1]  <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_inflight <= w_issue;
      if (w_issue) r_issued <= r_issued + LEN_WIDTH'(1);
      if (w_pop) begin
        r_accepted <= r_accepted + LEN_WIDTH'(1);
        r_rd_ptr   <= ~r_rd_ptr;
      end
      // Buffer read latency is one cycle, so inflight marks valid rdata now.
      if (r_inflight) begin
        r_fifo[r_wr_ptr] <= w_ret_data;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            if (sel_i != 2'd3 && len_i != '0) begin
              r_sel      <= sel_i;
              r_len      <= len_i;
              r_issued   <= '0;
              r_accepted <= '0;
              r_busy     <= 1'b1;
              r_state    <= S_READ;
            end else begin
              r_done <= 1'b1;
              r_err  <= (sel_i == 2'd3);
            end
          end
        end
        S_READ: begin
          if (w_last_issue) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_last_pop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_drain.sv
// Randomized and directed bench for result_drain: buffer models answer reads,
// a monitor logs issues and beats, and each command is scored against memory.
module tb_result_drain;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [1:0]  sel_i;
  logic [14:0] len_i;
  logic        sa_data_rden_o;
  logic [13:0] sa_data_rdptr_o;
  logic [7:0]  sa_data_rdata_i;
  logic        fc_data_rden_o;
  logic [9:0]  fc_data_rdptr_o;
  logic [7:0]  fc_data_rdata_i;
  logic        pool_address_rden_o;
  logic [13:0] pool_address_rdptr_o;
  logic [9:0]  pool_address_rdata_i;
  logic        m_valid_o;
  logic        m_ready_i;
  logic [9:0]  m_data_o;
  logic        m_last_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  result_drain #(.DATA_WIDTH(8), .PADDR_WIDTH(10), .LEN_WIDTH(15)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .sel_i(sel_i), .len_i(len_i),
    .sa_data_rden_o(sa_data_rden_o), .sa_data_rdptr_o(sa_data_rdptr_o),
    .sa_data_rdata_i(sa_data_rdata_i),
    .fc_data_rden_o(fc_data_rden_o), .fc_data_rdptr_o(fc_data_rdptr_o),
    .fc_data_rdata_i(fc_data_rdata_i),
    .pool_address_rden_o(pool_address_rden_o), .pool_address_rdptr_o(pool_address_rdptr_o),
    .pool_address_rdata_i(pool_address_rdata_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o), .m_last_o(m_last_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  logic [55:0] all_out;
  assign all_out = {sa_data_rden_o, sa_data_rdptr_o, fc_data_rden_o, fc_data_rdptr_o,
                    pool_address_rden_o, pool_address_rdptr_o, m_valid_o, m_data_o,
                    m_last_o, busy_o, done_o, err_o};

  logic [7:0] sa_mem   [16384];
  logic [7:0] fc_mem   [1024];
  logic [9:0] pool_mem [16384];

  int n_assert, n_fail, cyc, rdy_mode;
  int iss_cyc[$], iss_sel[$], iss_ptr[$];
  int beat_cyc[$], beat_data[$], beat_last[$];
  int done_cyc[$], err_cyc[$];
  int stab_err, multi_err, ptr_err, busy_err;
  int stab0, multi0, ptr0, busy0;
  logic       stall_prev;
  logic [9:0] prev_data;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0; stab_err = 0; multi_err = 0; ptr_err = 0; busy_err = 0;
    stall_prev = 1'b0; prev_data = '0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Buffers: one-cycle registered read.
  always @(posedge clk) begin
    if (sa_data_rden_o)      sa_data_rdata_i      <= sa_mem[sa_data_rdptr_o];
    if (fc_data_rden_o)      fc_data_rdata_i      <= fc_mem[fc_data_rdptr_o];
    if (pool_address_rden_o) pool_address_rdata_i <= pool_mem[pool_address_rdptr_o];
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: m_ready_i = 1'b1;
        1: m_ready_i = 1'($urandom_range(0, 1));
        2: m_ready_i = 1'b0;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if ((int'(sa_data_rden_o) + int'(fc_data_rden_o) + int'(pool_address_rden_o)) > 1)
      multi_err <= multi_err + 1;
    if ((!sa_data_rden_o && sa_data_rdptr_o != 0) || (!fc_data_rden_o && fc_data_rdptr_o != 0) ||
        (!pool_address_rden_o && pool_address_rdptr_o != 0))
      ptr_err <= ptr_err + 1;
    if (sa_data_rden_o) begin
      iss_cyc.push_back(cyc); iss_sel.push_back(0); iss_ptr.push_back(int'(sa_data_rdptr_o));
    end
    if (fc_data_rden_o) begin
      iss_cyc.push_back(cyc); iss_sel.push_back(1); iss_ptr.push_back(int'(fc_data_rdptr_o));
    end
    if (pool_address_rden_o) begin
      iss_cyc.push_back(cyc); iss_sel.push_back(2); iss_ptr.push_back(int'(pool_address_rdptr_o));
    end
    if (m_valid_o && m_ready_i) begin
      beat_cyc.push_back(cyc); beat_data.push_back(int'(m_data_o)); beat_last.push_back(int'(m_last_o));
    end
    if (done_o) done_cyc.push_back(cyc);
    if (err_o) err_cyc.push_back(cyc);
    if (done_o && busy_o) busy_err <= busy_err + 1;
    if (stall_prev && !(m_valid_o && m_data_o == prev_data)) stab_err <= stab_err + 1;
    stall_prev <= m_valid_o && !m_ready_i;
    prev_data  <= m_data_o;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -7;
  endfunction

  function automatic int ref_beat(input int sel, input int i);
    case (sel)
      0:       return int'(sa_mem[i % 16384]);
      1:       return int'(fc_mem[i % 1024]);
      default: return int'(pool_mem[i % 16384]);
    endcase
  endfunction

  task automatic clear_logs();
    iss_cyc.delete(); iss_sel.delete(); iss_ptr.delete();
    beat_cyc.delete(); beat_data.delete(); beat_last.delete();
    done_cyc.delete(); err_cyc.delete();
    stab0 = stab_err; multi0 = multi_err; ptr0 = ptr_err; busy0 = busy_err;
  endtask

  task automatic start_cmd(input int sel, input int len, output int t);
    @(posedge clk);
    #1;
    start_i = 1'b1; sel_i = 2'(sel); len_i = 15'(len);
    t = cyc;
    @(posedge clk);
    #1;
    start_i = 1'b0; sel_i = 2'($urandom_range(0, 3)); len_i = 15'($urandom);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cyc.size() == 0; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_cmd(input string tag, input int sel, input int len);
    int nd, nl, np, ns, wrap;
    nd = 0; nl = 0; np = 0; ns = 0;
    wrap = (sel == 1) ? 1024 : 16384;
    for (int i = 0; i < beat_data.size(); i++) begin
      if (i >= len || beat_data[i] != ref_beat(sel, i)) nd++;
      if (beat_last[i] != ((i == len - 1) ? 1 : 0)) nl++;
    end
    for (int i = 0; i < iss_ptr.size(); i++) begin
      if (iss_ptr[i] != i % wrap) np++;
      if (iss_sel[i] != sel) ns++;
    end
    chk({tag, " beat_count"}, beat_data.size(), len);
    chk({tag, " beat_data_mismatches"}, nd, 0);
    chk({tag, " last_flag_mismatches"}, nl, 0);
    chk({tag, " issue_count"}, iss_ptr.size(), len);
    chk({tag, " rdptr_mismatches"}, np, 0);
    chk({tag, " wrong_port_rden"}, ns, 0);
    chk({tag, " done_pulses"}, done_cyc.size(), 1);
    chk({tag, " err_pulses"}, err_cyc.size(), 0);
    chk({tag, " stall_stability_errors"}, stab_err - stab0, 0);
    chk({tag, " multi_rden"}, multi_err - multi0, 0);
    chk({tag, " idle_port_ptr_nonzero"}, ptr_err - ptr0, 0);
    chk({tag, " busy_with_done"}, busy_err - busy0, 0);
  endtask

  initial begin
    int t;
    n_assert = 0; n_fail = 0;
    rst_n = 1'b0; start_i = 1'b0; sel_i = '0; len_i = '0; m_ready_i = 1'b0; rdy_mode = 2;
    for (int i = 0; i < 16384; i++) begin
      sa_mem[i]   = 8'($urandom);
      pool_mem[i] = 10'($urandom);
    end
    for (int i = 0; i < 1024; i++) fc_mem[i] = 8'($urandom);
    sa_mem[0] = 8'h11; sa_mem[1] = 8'h22; sa_mem[2] = 8'h33; sa_mem[3] = 8'h44;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_all_outputs", 64'(all_out), 64'd0);
    rst_n = 1'b1;

    // SA read, ready held high: exact pipeline timing.
    rdy_mode = 0; m_ready_i = 1'b1;
    clear_logs();
    start_cmd(0, 4, t);
    chk("sa4 busy_at_T+1", busy_o, 1);
    wait_done(100);
    check_cmd("sa4", 0, 4);
    chk("sa4 first_rden_cycle", qget(iss_cyc, 0), t + 1);
    chk("sa4 last_rden_cycle", qget(iss_cyc, 3), t + 4);
    chk("sa4 first_beat_cycle", qget(beat_cyc, 0), t + 3);
    chk("sa4 last_beat_cycle", qget(beat_cyc, 3), t + 6);
    chk("sa4 last_beat_value", qget(beat_data, 3), 32'h044);
    chk("sa4 done_cycle", qget(done_cyc, 0), t + 7);
    chk("sa4 busy_after_done", busy_o, 0);

    // Pool addresses under backpressure.
    rdy_mode = 2; m_ready_i = 1'b0;
    clear_logs();
    start_cmd(2, 5, t);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("pool5 rden_before_accept", iss_cyc.size(), 2);
    chk("pool5 beats_before_accept", beat_data.size(), 0);
    chk("pool5 valid_while_stalled", m_valid_o, 1);
    rdy_mode = 0; m_ready_i = 1'b1;
    wait_done(100);
    check_cmd("pool5", 2, 5);

    // FC narrow pointer wraps past 1023.
    clear_logs();
    start_cmd(1, 1025, t);
    wait_done(3000);
    check_cmd("fc1025", 1, 1025);
    chk("fc1025 ptr_1023", qget(iss_ptr, 1023), 1023);
    chk("fc1025 ptr_wrap", qget(iss_ptr, 1024), 0);

    // Degenerate commands.
    clear_logs();
    start_cmd(0, 0, t);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("len0 done_cycle", qget(done_cyc, 0), t + 1);
    chk("len0 done_pulses", done_cyc.size(), 1);
    chk("len0 err_pulses", err_cyc.size(), 0);
    chk("len0 rden_count", iss_cyc.size(), 0);
    clear_logs();
    start_cmd(3, 8, t);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("sel3 done_cycle", qget(done_cyc, 0), t + 1);
    chk("sel3 err_cycle", qget(err_cyc, 0), t + 1);
    chk("sel3 err_pulses", err_cyc.size(), 1);
    chk("sel3 rden_count", iss_cyc.size(), 0);
    chk("sel3 busy", busy_o, 0);

    // Start while busy is ignored.
    clear_logs();
    start_cmd(0, 6, t);
    start_i = 1'b1; sel_i = 2'd1; len_i = 15'd2;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_done(100);
    check_cmd("overlap", 0, 6);

    // Reset after three beats aborts the command.
    clear_logs();
    start_cmd(2, 10, t);
    for (int i = 0; i < 100 && beat_data.size() < 3; i++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort outputs_zero", 64'(all_out), 64'd0);
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    chk("abort no_done", done_cyc.size(), 0);
    clear_logs();
    start_cmd(2, 3, t);
    wait_done(100);
    check_cmd("post_reset", 2, 3);
    chk("post_reset first_ptr", qget(iss_ptr, 0), 0);

    // Random ready toggling, 200 entries per buffer.
    for (int s = 0; s < 3; s++) begin
      rdy_mode = 1;
      clear_logs();
      start_cmd(s, 200, t);
      wait_done(5000);
      check_cmd($sformatf("rand_sel%0d", s), s, 200);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/result_drain.md
# result_drain

Host-side read engine for the accumulator/pooling result buffers. A single `start_i` command drains `len_i` consecutive entries from one of three buffers: SA feature-map data, FC output data, or pooling addresses. The engine issues `*_rden`/`*_rdptr` to the buffer read ports and returns each entry as a valid/ready stream with a last-beat flag. It is the consumer end of the buffers written by the accumulate/pool path, and sits between the top-level result read ports and the host interface.

## Interface
- `DATA_WIDTH`, 8, width of SA and FC result entries.
- `PADDR_WIDTH`, 10, width of pooling-address entries; also the stream data width.
- `LEN_WIDTH`, 15, width of the length field (maximum 16384 entries).
- `clk` in 1: clock; everything is on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start_i` in 1: one-cycle command strobe; sampled only in IDLE.
- `sel_i` in 2: buffer select. 0 = SA data, 1 = FC data, 2 = pool address, 3 = illegal.
- `len_i` in LEN_WIDTH: number of entries to read, starting at pointer 0.
- `sa_data_rden_o` out 1, `sa_data_rdptr_o` out 14: SA buffer read port.
- `sa_data_rdata_i` in DATA_WIDTH: SA read data.
- `fc_data_rden_o` out 1, `fc_data_rdptr_o` out 10: FC buffer read port.
- `fc_data_rdata_i` in DATA_WIDTH: FC read data.
- `pool_address_rden_o` out 1, `pool_address_rdptr_o` out 14: pool-address buffer read port.
- `pool_address_rdata_i` in PADDR_WIDTH: pool-address read data.
- `m_valid_o` out 1, `m_ready_i` in 1: output stream handshake.
- `m_data_o` out PADDR_WIDTH: stream data. SA and FC entries are zero-extended.
- `m_last_o` out 1: marks the final beat of the command.
- `busy_o` out 1: high from command acceptance until the last beat is accepted.
- `done_o` out 1: one-cycle completion pulse.
- `err_o` out 1: one-cycle pulse coincident with `done_o` when the command was rejected.

## Operation
- Registered state machine with states IDLE, READ, DRAIN.
- **IDLE**
  - `start_i` with `sel_i` in 0..2 and `len_i` ≠ 0: latch `sel`, `len`, clear the issue and accept counters, go to READ.
  - `start_i` with `len_i` = 0 or `sel_i` = 3: stay in IDLE and pulse `done_o` the next cycle. `err_o` also pulses in that cycle only when `sel_i` = 3.
- **READ**
  - Each cycle, a read is issued when both hold: issued < len, and (fifo_count + inflight − pop) < 2.
  - `pop` = `m_valid_o & m_ready_i`.
  - Issuing asserts only the selected port's `rden`, with `rdptr` = issue counter. Narrower pointers take the counter's low bits.
  - When the last read issues, go to DRAIN.
- **DRAIN**
  - When the beat with accept counter = len−1 is popped, go to IDLE, pulse `done_o`, and drop `busy_o` in the same cycle `done_o` rises.
- **Return path**
  - Read latency is exactly 1 cycle. `inflight` is a 1-bit register set by issue.
  - Returned data is written into a 2-entry FIFO. The FIFO head drives `m_data_o`, and `m_valid_o` = FIFO not empty.
- `m_last_o` = `m_valid_o` && accept counter = len−1.
- The stream obeys AXI-style rules: once `m_valid_o` is high, it stays high and `m_data_o` is held stable until accepted.
- `start_i` while `busy_o` = 1 is ignored, with no error.
- `sel_i` and `len_i` changes after acceptance have no effect.
- At most one `rden` output is high in any cycle. Unselected ports hold `rden` = 0 and `rdptr` = 0.

## Timing
- **Reset:** state IDLE, counters 0, FIFO empty. All outputs 0: `*_rden_o`, `*_rdptr_o`, `m_valid_o`, `m_data_o`, `m_last_o`, `busy_o`, `done_o`, `err_o`.
- **Pipeline, with start accepted at cycle T:**
  - `busy_o` = 1 from T+1.
  - First `rden` at T+1.
  - Read data valid on `*_rdata_i` at T+2 and captured into the FIFO at the end of T+2.
  - First `m_valid_o` at T+3.
- **Throughput:** with `m_ready_i` held high, one read issues per cycle and one beat per cycle from T+3. The last beat is at T+2+len; `done_o` and `busy_o` = 0 at T+3+len.
- **Backpressure:** with `m_ready_i` low, at most 2 reads are outstanding (FIFO entries + inflight). Issuing stops with no data loss and resumes the cycle a pop occurs.
- A pop and a FIFO write in the same cycle keep the count unchanged.
- **Reset mid-command:** abort immediately with no `done_o`. Any in-flight return data is discarded.

## Test plan
- **SA read, `m_ready_i` held high:** `sel_i`=0, `len_i`=4, buffer holds 0x11,0x22,0x33,0x44 → `sa_data_rdptr_o` 0,1,2,3 on T+1..T+4. Beats 0x011,0x022,0x033,0x044 on T+3..T+6, `m_last_o` only on 0x044. `done_o` at T+7.
- **Pool address under backpressure:** `sel_i`=2, `len_i`=5, `m_ready_i` low for 6 cycles after start → exactly 2 `rden` pulses before the first accept. `m_data_o` is stable while stalled. All 5 addresses are delivered in order, with `fc_data_rden_o`/`sa_data_rden_o` never asserted.
- **FC wrap of narrow pointer:** `sel_i`=1, `len_i`=1025 → `fc_data_rdptr_o` reaches 1023 then 0. 1025 beats are delivered, last beat flagged.
- **Degenerate commands:** `len_i`=0 → `done_o` next cycle, `err_o`=0, no `rden`. `sel_i`=3 with `len_i`=8 → `done_o` and `err_o` pulse together, no `rden`.
- **Overlap and reset:** `start_i` re-asserted while busy with `len_i`=2 → ignored, and the original 6-beat command completes unchanged. A second run with `rst_n` low for 1 cycle after 3 beats → all outputs 0 next cycle, no `done_o`, and a new command after reset starts from pointer 0.
- **Random ready toggling, 200 entries per buffer:** every beat matches a scoreboard in order, and pointers are strictly sequential.
